// File: rtl/cpu_pkg.sv
// Shared CPU constants and the MEM/WB controller state type.
// MEMWB_TIMEOUT_CYCLES is used only when MEMWB_TIMEOUT_EN is defined.
package cpu_pkg;

  localparam int unsigned XLEN                 = 32;
  localparam int unsigned REG_ADDR_W           = 5;
  localparam int unsigned MEMWB_TIMEOUT_CYCLES = 15;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memwb_state_e;

endpackage

// File: rtl/memwb_watchdog.sv
// Counts ACCESS cycles without a memory ack and flags the cycle that reaches the limit.
// Instantiated by mem_wb_ctrl only when MEMWB_TIMEOUT_EN is defined.
module memwb_watchdog
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [3:0] count;

  // The limit-reaching cycle is flagged combinationally so the FSM can leave ACCESS on that edge.
  assign expired = count_en && (count == 4'(MEMWB_TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/mem_wb_ctrl.sv
// MEM stage data-memory handshake controller and MEM/WB pipeline register.
// Optional watchdog timeout and err_o port are enabled by defining MEMWB_TIMEOUT_EN.
module mem_wb_ctrl
  import cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [XLEN-1:0]       ALU_Result_i,
  input  logic [XLEN-1:0]       MemWrite_Data_i,
  input  logic [REG_ADDR_W-1:0] RdAddr_i,
  input  logic                  RegWrite_i,
  input  logic                  MemtoReg_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [XLEN-1:0]       mem_addr_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  output logic                  stall_o,
  output logic [XLEN-1:0]       ALU_Result_o,
  output logic [XLEN-1:0]       ReadData_o,
  output logic [REG_ADDR_W-1:0] RdAddr_o,
  output logic                  RegWrite_o,
  output logic                  MemtoReg_o
`ifdef MEMWB_TIMEOUT_EN
  ,
  output logic                  err_o
`endif
);

  memwb_state_e state, state_next;

  logic mem_op;
  logic pass;
  logic issue;
  logic complete;
  logic abort;
  logic expired;

  assign mem_op = MemRead_i | MemWrite_i;

`ifdef MEMWB_TIMEOUT_EN
  memwb_watchdog u_watchdog (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .clear    (issue),
    .count_en ((state == ACCESS) && !mem_ack_i),
    .expired  (expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if (abort) begin
      err_o <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i && mem_op)        state_next = ACCESS;
      ACCESS:  if (mem_ack_i || expired)     state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  always_comb begin
    pass     = 1'b0;
    issue    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    stall_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          issue   = mem_op;
          pass    = !mem_op;
          stall_o = mem_op;
        end
      end
      ACCESS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        complete = mem_ack_i;
        abort    = !mem_ack_i && expired;
        stall_o  = !mem_ack_i && !expired;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      ALU_Result_o <= '0;
      ReadData_o   <= '0;
      RdAddr_o     <= '0;
      RegWrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
    end else begin
      if (pass) begin
        ALU_Result_o <= ALU_Result_i;
        ReadData_o   <= '0;
        RdAddr_o     <= RdAddr_i;
        RegWrite_o   <= RegWrite_i;
        MemtoReg_o   <= MemtoReg_i;
      end else if (issue) begin
        mem_req_o    <= 1'b1;
        mem_we_o     <= MemWrite_i;
        mem_addr_o   <= ALU_Result_i;
        mem_wdata_o  <= MemWrite_Data_i;
        RegWrite_o   <= 1'b0;
      end else if (complete) begin
        mem_req_o    <= 1'b0;
        ReadData_o   <= mem_we_o ? '0 : mem_rdata_i;
        ALU_Result_o <= ALU_Result_i;
        RdAddr_o     <= RdAddr_i;
        RegWrite_o   <= RegWrite_i;
        MemtoReg_o   <= MemtoReg_i;
      end else if (state == ACCESS) begin
        RegWrite_o   <= 1'b0;
        if (abort) begin
          mem_req_o  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Self-checking bench for mem_wb_ctrl: directed vector table, reset/timeout sequences, random vs reference model.
// Define MEMWB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_mem_wb_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] ALU_Result_i;
  logic [31:0] MemWrite_Data_i;
  logic [4:0]  RdAddr_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] ALU_Result_o, ReadData_o;
  logic [4:0]  RdAddr_o;
  logic        RegWrite_o, MemtoReg_o;
`ifdef MEMWB_TIMEOUT_EN
  logic        err_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_wb_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .ALU_Result_i    (ALU_Result_i),
    .MemWrite_Data_i (MemWrite_Data_i),
    .RdAddr_i        (RdAddr_i),
    .RegWrite_i      (RegWrite_i),
    .MemtoReg_i      (MemtoReg_i),
    .MemRead_i       (MemRead_i),
    .MemWrite_i      (MemWrite_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rdata_i     (mem_rdata_i),
    .stall_o         (stall_o),
    .ALU_Result_o    (ALU_Result_o),
    .ReadData_o      (ReadData_o),
    .RdAddr_o        (RdAddr_o),
    .RegWrite_o      (RegWrite_o),
    .MemtoReg_o      (MemtoReg_o)
`ifdef MEMWB_TIMEOUT_EN
    ,
    .err_o           (err_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        start, rd, wr;
    logic [31:0] alu, wdata;
    logic [4:0]  rdaddr;
    logic        regw, m2r, ack;
    logic [31:0] rdata;
    logic        x_stall, x_req, x_we;
    logic [31:0] x_addr, x_wdata, x_alu, x_rdata;
    logic [4:0]  x_rd;
    logic        x_regw, x_m2r;
  } vec_t;

  vec_t tv[13];

  task automatic drive(input logic st, input logic rd, input logic wr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] ra, input logic rw, input logic m2r,
                       input logic ack, input logic [31:0] rdat);
    start_i = st; MemRead_i = rd; MemWrite_i = wr; ALU_Result_i = alu;
    MemWrite_Data_i = wd; RdAddr_i = ra; RegWrite_i = rw; MemtoReg_i = m2r;
    mem_ack_i = ack; mem_rdata_i = rdat;
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy, m_req, m_we, m_regw, m_m2r, m_err;
  logic [31:0] m_addr, m_wdata, m_alu, m_rdata;
  logic [4:0]  m_rd;
  int          m_waited;

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_we = 0; m_regw = 0; m_m2r = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_alu = '0; m_rdata = '0; m_rd = '0; m_waited = 0;
  endtask

  function automatic bit timeout_now();
`ifdef MEMWB_TIMEOUT_EN
    return m_busy && !mem_ack_i && (m_waited + 1 == 15);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_stall();
    if (!m_busy) return start_i && (MemRead_i || MemWrite_i);
    return !mem_ack_i && !timeout_now();
  endfunction

  task automatic model_edge();
    if (!m_busy) begin
      if (start_i && (MemRead_i || MemWrite_i)) begin
        m_busy = 1; m_req = 1; m_we = MemWrite_i; m_addr = ALU_Result_i;
        m_wdata = MemWrite_Data_i; m_regw = 0; m_waited = 0;
      end else if (start_i) begin
        m_alu = ALU_Result_i; m_rd = RdAddr_i; m_regw = RegWrite_i;
        m_m2r = MemtoReg_i; m_rdata = '0;
      end
    end else if (mem_ack_i) begin
      m_busy = 0; m_req = 0; m_rdata = m_we ? 32'h0 : mem_rdata_i;
      m_alu = ALU_Result_i; m_rd = RdAddr_i; m_regw = RegWrite_i; m_m2r = MemtoReg_i;
    end else begin
      m_regw = 0;
      if (timeout_now()) begin
        m_busy = 0; m_req = 0; m_err = 1;
      end
      m_waited++;
    end
  endtask

  task automatic check_model();
    check("rnd_req",   mem_req_o,    m_req);
    check("rnd_we",    mem_we_o,     m_we);
    check("rnd_addr",  mem_addr_o,   m_addr);
    check("rnd_wdata", mem_wdata_o,  m_wdata);
    check("rnd_alu",   ALU_Result_o, m_alu);
    check("rnd_rdata", ReadData_o,   m_rdata);
    check("rnd_rd",    RdAddr_o,     m_rd);
    check("rnd_regw",  RegWrite_o,   m_regw);
    check("rnd_m2r",   MemtoReg_o,   m_m2r);
`ifdef MEMWB_TIMEOUT_EN
    check("rnd_err",   err_o,        m_err);
`endif
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  initial begin
    tv[0]  = '{1'b1,1'b0,1'b0,32'h10,32'h0,5'd5,1'b1,1'b0,1'b0,32'h0,
               1'b0,1'b0,1'b0,32'h0,32'h0,32'h10,32'h0,5'd5,1'b1,1'b0};
    tv[1]  = '{1'b1,1'b1,1'b0,32'h40,32'h55,5'd7,1'b1,1'b1,1'b0,32'h0,
               1'b1,1'b1,1'b0,32'h40,32'h55,32'h10,32'h0,5'd5,1'b0,1'b0};
    tv[2]  = tv[1];
    tv[3]  = tv[1];
    tv[4]  = '{1'b1,1'b1,1'b0,32'h40,32'h55,5'd7,1'b1,1'b1,1'b1,32'hDEADBEEF,
               1'b0,1'b0,1'b0,32'h40,32'h55,32'h40,32'hDEADBEEF,5'd7,1'b1,1'b1};
    tv[5]  = '{1'b1,1'b0,1'b1,32'h80,32'h1234,5'd0,1'b0,1'b0,1'b0,32'h0,
               1'b1,1'b1,1'b1,32'h80,32'h1234,32'h40,32'hDEADBEEF,5'd7,1'b0,1'b1};
    tv[6]  = '{1'b1,1'b0,1'b1,32'h80,32'h1234,5'd0,1'b0,1'b0,1'b1,32'hAAAA5555,
               1'b0,1'b0,1'b1,32'h80,32'h1234,32'h80,32'h0,5'd0,1'b0,1'b0};
    tv[7]  = '{1'b1,1'b1,1'b1,32'hC0,32'h77,5'd3,1'b1,1'b1,1'b0,32'h0,
               1'b1,1'b1,1'b1,32'hC0,32'h77,32'h80,32'h0,5'd0,1'b0,1'b0};
    tv[8]  = '{1'b1,1'b1,1'b1,32'hC0,32'h77,5'd3,1'b1,1'b1,1'b1,32'h99,
               1'b0,1'b0,1'b1,32'hC0,32'h77,32'hC0,32'h0,5'd3,1'b1,1'b1};
    tv[9]  = '{1'b0,1'b1,1'b0,32'h100,32'h0,5'd9,1'b1,1'b1,1'b1,32'hFFFF,
               1'b0,1'b0,1'b1,32'hC0,32'h77,32'hC0,32'h0,5'd3,1'b1,1'b1};
    tv[10] = '{1'b1,1'b1,1'b0,32'h100,32'h0,5'd9,1'b1,1'b1,1'b0,32'h0,
               1'b1,1'b1,1'b0,32'h100,32'h0,32'hC0,32'h0,5'd3,1'b0,1'b1};
    tv[11] = '{1'b1,1'b1,1'b0,32'h100,32'h0,5'd9,1'b1,1'b1,1'b1,32'h5A5A,
               1'b0,1'b0,1'b0,32'h100,32'h0,32'h100,32'h5A5A,5'd9,1'b1,1'b1};
    tv[12] = '{1'b0,1'b0,1'b0,32'h333,32'h0,5'd1,1'b1,1'b0,1'b0,32'h0,
               1'b0,1'b0,1'b0,32'h100,32'h0,32'h100,32'h5A5A,5'd9,1'b1,1'b1};

    do_reset();
    check("rst_req",   mem_req_o,    1'b0);
    check("rst_regw",  RegWrite_o,   1'b0);
    check("rst_alu",   ALU_Result_o, 32'h0);
    check("rst_addr",  mem_addr_o,   32'h0);
    check("rst_stall", stall_o,      1'b0);

    // Directed table: stall_o checked mid-cycle, registered outputs just after the edge.
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].start, tv[i].rd, tv[i].wr, tv[i].alu, tv[i].wdata, tv[i].rdaddr,
            tv[i].regw, tv[i].m2r, tv[i].ack, tv[i].rdata);
      @(negedge clk_i);
      check($sformatf("tv%0d_stall", i), stall_o, tv[i].x_stall);
      @(posedge clk_i);
      #1;
      check($sformatf("tv%0d_req", i),   mem_req_o,    tv[i].x_req);
      check($sformatf("tv%0d_we", i),    mem_we_o,     tv[i].x_we);
      check($sformatf("tv%0d_addr", i),  mem_addr_o,   tv[i].x_addr);
      check($sformatf("tv%0d_wdata", i), mem_wdata_o,  tv[i].x_wdata);
      check($sformatf("tv%0d_alu", i),   ALU_Result_o, tv[i].x_alu);
      check($sformatf("tv%0d_rdata", i), ReadData_o,   tv[i].x_rdata);
      check($sformatf("tv%0d_rd", i),    RdAddr_o,     tv[i].x_rd);
      check($sformatf("tv%0d_regw", i),  RegWrite_o,   tv[i].x_regw);
      check($sformatf("tv%0d_m2r", i),   MemtoReg_o,   tv[i].x_m2r);
    end

    // Reset asserted mid-ACCESS abandons the request; a stray ack afterwards is ignored.
    drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk_i);
    #1 check("ar_req_before", mem_req_o, 1'b1);
    #2 start_i = 1'b0; rst_i = 1'b0;
    #1;
    check("ar_req_async",  mem_req_o,  1'b0);
    check("ar_regw_async", RegWrite_o, 1'b0);
    check("ar_addr_async", mem_addr_o, 32'h0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("ar_req_after",   mem_req_o,    1'b0);
    check("ar_regw_after",  RegWrite_o,   1'b0);
    check("ar_rdata_after", ReadData_o,   32'h0);
    check("ar_alu_after",   ALU_Result_o, 32'h0);
    check("ar_stall_after", stall_o,      1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
    check("ar_idle_stall", stall_o, 1'b0);
    @(posedge clk_i);
    #1;
    check("ar_idle_alu",  ALU_Result_o, 32'h44);
    check("ar_idle_regw", RegWrite_o,   1'b1);

`ifdef MEMWB_TIMEOUT_EN
    // Unacknowledged load: the 15th ACCESS cycle releases stall and flags err_o.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk_i);
    #1 check("to_req_issued", mem_req_o, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_i);
      check($sformatf("to_stall_c%0d", c), stall_o, (c < 15) ? 1'b1 : 1'b0);
      check($sformatf("to_err_c%0d", c),   err_o,   1'b0);
      @(posedge clk_i);
      #1;
    end
    check("to_err",  err_o,      1'b1);
    check("to_req",  mem_req_o,  1'b0);
    check("to_regw", RegWrite_o, 1'b0);
    start_i = 1'b0;
    #1 check("to_stall_idle", stall_o, 1'b0);
`endif

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      int unsigned kind;
      kind = $urandom_range(99);
      start_i         = ($urandom_range(99) < 80);
      MemRead_i       = (kind >= 50 && kind < 75) || (kind >= 95);
      MemWrite_i      = (kind >= 75);
      ALU_Result_i    = $urandom;
      MemWrite_Data_i = $urandom;
      RdAddr_i        = 5'($urandom);
      RegWrite_i      = 1'($urandom);
      MemtoReg_i      = 1'($urandom);
      mem_ack_i       = m_busy ? ($urandom_range(99) < 30) : ($urandom_range(99) < 20);
      mem_rdata_i     = $urandom;
      @(negedge clk_i);
      check_model();
      check("rnd_stall", stall_o, model_stall());
      @(posedge clk_i);
      model_edge();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_ctrl.md
MEM_WB_CTRL -- requirements
Module: mem_wb_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  reset; asynchronous, active-low
- start_i  in  1  pipeline enable; low holds all pipeline outputs
- ALU_Result_i  in  32  EX/MEM ALU result; memory address for loads and stores
- MemWrite_Data_i  in  32  EX/MEM store data
- RdAddr_i  in  5  EX/MEM destination register
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  EX/MEM controls
- mem_req_o  out  1  data-memory request, registered
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  registered access address
- mem_wdata_o  out  32  registered store data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- stall_o  out  1  freeze request to PC, IF/ID, ID/EX and EX/MEM registers
- ALU_Result_o, ReadData_o  out  32 each  MEM/WB values
- RdAddr_o  out  5; RegWrite_o, MemtoReg_o  out  1 each  MEM/WB controls

Function
REQ-002 SHALL implement FSM states IDLE and ACCESS.
REQ-003 In IDLE with start_i=1 and MemRead_i=0 and MemWrite_i=0, SHALL on the clock edge:
- load the MEM/WB outputs from the inputs
- set ReadData_o=0
- take 1-cycle latency and assert no stall.
REQ-004 In IDLE with start_i=1 and (MemRead_i or MemWrite_i):
- SHALL drive stall_o=1 combinationally in the same cycle
- on the edge, SHALL latch mem_addr_o=ALU_Result_i, mem_wdata_o=MemWrite_Data_i, mem_we_o=MemWrite_i
- SHALL set mem_req_o=1 and enter ACCESS
- SHALL load RegWrite_o=0 (bubble).
REQ-005 If MemRead_i and MemWrite_i are both 1, SHALL treat the access as a write.
REQ-006 In ACCESS, stall_o SHALL equal NOT mem_ack_i. mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o SHALL stay stable until ack.
REQ-007 On an ACCESS edge with mem_ack_i=1, SHALL:
- clear mem_req_o
- load ReadData_o=mem_rdata_i (reads) or 0 (writes)
- load ALU_Result_o, RdAddr_o, RegWrite_o and MemtoReg_o from the inputs
- return to IDLE
Minimum load/store latency is therefore 2 cycles.
REQ-008 On an ACCESS edge with mem_ack_i=0, the MEM/WB outputs SHALL hold, except RegWrite_o=0.
REQ-009 start_i=0 SHALL hold the MEM/WB outputs and block new accesses in IDLE (stall_o=0). An in-flight ACCESS SHALL still complete on ack.
REQ-010 SHALL ignore mem_ack_i while in IDLE.

Reset
REQ-011 rst_i low SHALL asynchronously force:
- state IDLE
- every output register to 0, including mem_req_o=0 and RegWrite_o=0
REQ-012 Reset during ACCESS SHALL abandon the request with no completion and no write-back.

Configuration
REQ-013 With macro MEMWB_TIMEOUT_EN defined:
- SHALL add output err_o (1 bit, sticky, cleared only by reset)
- SHALL add a 4-bit counter that clears on entering ACCESS and counts ACCESS cycles without ack
- on reaching 15, SHALL drop mem_req_o, set err_o=1, return to IDLE with RegWrite_o=0, and release stall_o.
REQ-014 Without MEMWB_TIMEOUT_EN, SHALL have no err_o port and wait indefinitely for ack.

Structure
REQ-015 Shared package cpu_pkg SHALL hold:
- XLEN=32, REG_ADDR_W=5
- the FSM state enum
- MEMWB_TIMEOUT_CYCLES=15
REQ-016 The timeout counter SHALL be sub-module memwb_watchdog, instantiated only under MEMWB_TIMEOUT_EN. The FSM stays in mem_wb_ctrl.

Verification
REQ-017 The bench SHALL cover:
- ALU op, RdAddr_i=5, ALU_Result_i=0x10, RegWrite_i=1 -> next edge RdAddr_o=5, ALU_Result_o=0x10, RegWrite_o=1; stall_o never 1.
- Load from 0x40, ack in 3rd ACCESS cycle, mem_rdata_i=0xDEADBEEF -> stall_o high 3 cycles; mem_addr_o=0x40; then ReadData_o=0xDEADBEEF, RegWrite_o=1.
- Store 0x1234 to 0x80, immediate ack -> mem_we_o=1, mem_wdata_o=0x1234; stall_o high 1 cycle; ReadData_o=0.
- rst_i low during ACCESS -> mem_req_o=0 and RegWrite_o=0 immediately; after release, state IDLE; stray ack ignored.
- start_i=0 with a pending load -> no request, outputs unchanged; start_i=1 -> request issued next edge.
- MEMWB_TIMEOUT_EN, no ack -> after 15 ACCESS cycles err_o=1, mem_req_o=0, stall_o=0.
